prog_loader_rom: RTL
====================

Name: prog_loader_rom

Overview:
- Program memory plus serial load controller sitting directly upstream of the 4-bit CPU core.
- Serves the 8-bit instruction word (opcode in bits 7:4, immediate in bits 3:0) combinationally for the CPU's 4-bit instruction pointer.
- Accepts a new 16-byte program over a valid/ready byte stream.
- Holds the CPU in reset through clear, load and a short release hold, so the core always restarts at address 0 on a fully written program.

Parameters:
- AW, 4, address width; DEPTH = 2**AW = 16 entries.
- DW, 8, instruction word width.
- HOLD_CYCLES, 2, cycles cpu_n_reset stays low after the last write before release (legal range 1..15).

Ports:
- clk  input  1  single system clock, rising edge
- n_reset  input  1  synchronous active-low reset
- addr  input  AW  instruction address from the CPU
- data  output  DW  instruction word at addr, combinational read
- ld_start  input  1  request to begin a program load; sampled only in IDLE
- ld_abort  input  1  cancel an in-progress load
- ld_valid  input  1  ld_data holds a byte
- ld_data  input  DW  program byte, written in ascending address order
- ld_ready  output  1  loader accepts a byte this cycle
- ld_busy  output  1  high in every state except IDLE
- ld_done  output  1  one-cycle pulse when a complete 16-byte load is released
- ld_err  output  1  sticky; set by abort, cleared by the next ld_start
- cpu_n_reset  output  1  registered active-low reset driven to the CPU core

Behaviour:
- Clock and reset: one clock, clk. Reset is n_reset, synchronous and active-low, sampled on the rising clk edge.
- Reset values:
  - state = CLEAR, ptr = 0, hold_cnt = 0.
  - cpu_n_reset = 0, ld_ready = 0, ld_busy = 1, ld_done = 0, ld_err = 0.
  - Memory contents are not reset directly; CLEAR zero-fills them.
- States: CLEAR, IDLE, LOAD, HOLD.
- CLEAR:
  - Writes 8'h00 to mem[ptr] and increments ptr each cycle.
  - After the write of ptr = 15, goes to HOLD with ptr = 0.
  - Takes 16 cycles; ld_start and ld_valid are ignored.
  - 8'h00 decodes as ADD A,0, so an unloaded program is a NOP loop.
- IDLE:
  - cpu_n_reset = 1, ld_busy = 0, ld_ready = 0.
  - On ld_start: go to LOAD, set ptr = 0, clear ld_err, drive cpu_n_reset = 0 from the next cycle.
- LOAD:
  - ld_ready = 1.
  - On ld_valid & ld_ready: mem[ptr] <= ld_data, ptr increments.
  - The write with ptr = 15 moves to HOLD and sets the internal flag complete = 1.
  - No ld_valid means wait indefinitely; the CPU stays in reset.
- Abort in LOAD:
  - ld_abort has priority over a simultaneous byte; that byte is not written.
  - Set ld_err = 1, complete = 0, go to HOLD.
  - Bytes already written stay in memory; unwritten entries keep their previous contents.
- HOLD:
  - cpu_n_reset = 0, ld_ready = 0.
  - hold_cnt counts 0..HOLD_CYCLES-1, then goes to IDLE.
  - ld_done pulses for one cycle on the HOLD->IDLE edge only when complete = 1.
- cpu_n_reset is a registered output, low in CLEAR, LOAD and HOLD.
  - It rises on the first IDLE cycle, so the CPU's first fetch after release is addr 0.
- data = mem[addr] at all times, with no clock latency.
  - A write takes effect in the cycle after the writing edge.
  - Read-during-write to the same address returns the old word.
- ptr is AW bits plus an end flag; it never wraps into a second pass.
- ld_start outside IDLE is ignored, not queued.
- ld_abort outside LOAD is ignored.
- Reset asserted mid-LOAD or mid-HOLD: the next state is CLEAR, the partial program is discarded (zero-filled), and no ld_done is produced.

Decomposition:
- Shared package/include holds:
  - state encoding constants: CLEAR = 2'd0, IDLE = 2'd1, LOAD = 2'd2, HOLD = 2'd3.
  - AW and DW defaults.
  - the NOP word 8'h00.
- One natural sub-module: prog_mem, a DEPTH x DW register array with one synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
- FSM, pointer and hold counter live in prog_loader_rom.

Test Plan:
- Reset, then wait: ld_busy = 1 for 16 + HOLD_CYCLES cycles, cpu_n_reset rises afterwards, data = 8'h00 for every addr 0..15.
- ld_start, then 16 back-to-back bytes 8'h31, 8'h00..8'h0E: cpu_n_reset is low throughout, ld_done pulses once HOLD_CYCLES after the last byte, and mem[0] = 8'h31 (MOV A,1).
- Load with ld_valid deasserted every other cycle: only handshaked bytes are written, final contents are identical to the back-to-back case, no skipped or duplicated address.
- Abort after 5 bytes: ld_err = 1, no ld_done, addr 0..4 hold new bytes, addr 5..15 hold old contents, cpu_n_reset released after HOLD_CYCLES.
- ld_abort and ld_valid in the same LOAD cycle: that byte is not written; ld_start while in LOAD or HOLD has no effect.
- n_reset pulsed low for one cycle after byte 8: state goes to CLEAR, all 16 entries read 8'h00 afterwards, no ld_done, ld_err = 0.

Source files
------------

// File: rtl/prog_loader_rom_pkg.sv
// Shared definitions for the program ROM loader: FSM state encoding,
// default geometry and the zero-fill word.
package prog_loader_rom_pkg;

   localparam int DEF_AW          = 4;
   localparam int DEF_DW          = 8;
   localparam int DEF_HOLD_CYCLES = 2;

   // 8'h00 decodes as ADD A,0, so a cleared program is a NOP loop.
   localparam logic [7:0] NOP_WORD = 8'h00;

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      IDLE  = 2'd1,
      LOAD  = 2'd2,
      HOLD  = 2'd3
   } state_t;

endpackage

// File: rtl/prog_loader_rom_mem.sv
// DEPTH x DW program store: one synchronous write port and one
// asynchronous read port (read-during-write returns the old word).
module prog_loader_rom_mem #(
   parameter int AW = 4,
   parameter int DW = 8
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   localparam int DEPTH = 2 ** AW;

   logic [DW-1:0] r_mem [DEPTH];

   // write port; contents are initialised by the loader's zero-fill pass
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/prog_loader_rom.sv
// Program memory for the 4-bit CPU plus a valid/ready serial loader that
// keeps the CPU in reset while the program is cleared, loaded and settled.
module prog_loader_rom
   import prog_loader_rom_pkg::*;
#(
   parameter int AW          = DEF_AW,
   parameter int DW          = DEF_DW,
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
   input  logic          i_clk,
   input  logic          i_n_reset,
   input  logic [AW-1:0] i_addr,
   output logic [DW-1:0] o_data,
   input  logic          i_ld_start,
   input  logic          i_ld_abort,
   input  logic          i_ld_valid,
   input  logic [DW-1:0] i_ld_data,
   output logic          o_ld_ready,
   output logic          o_ld_busy,
   output logic          o_ld_done,
   output logic          o_ld_err,
   output logic          o_cpu_n_reset
);

   localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};
   localparam logic [AW:0]   PTR_ZERO  = {(AW+1){1'b0}};
   localparam logic [AW:0]   PTR_ONE   = {{AW{1'b0}}, 1'b1};
   localparam logic [3:0]    HOLD_LAST = 4'(HOLD_CYCLES - 1);
   localparam logic [3:0]    HOLD_ONE  = 4'd1;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [AW:0]   r_ptr;          // MSB is the end flag: a load never wraps
   logic [AW:0]   w_ptr_nxt;
   logic [3:0]    r_hold_cnt;
   logic [3:0]    w_hold_cnt_nxt;
   logic          r_complete;
   logic          w_complete_nxt;
   logic          r_ld_err;
   logic          w_ld_err_nxt;
   logic          w_done_nxt;
   logic          r_ld_ready;
   logic          r_ld_busy;
   logic          r_ld_done;
   logic          r_cpu_n_reset;
   logic          w_we;
   logic [AW-1:0] w_waddr;
   logic [DW-1:0] w_wdata;

   // next-state, pointer, hold counter and memory write decode
   always_comb begin
      w_state_nxt    = r_state;
      w_ptr_nxt      = r_ptr;
      w_hold_cnt_nxt = r_hold_cnt;
      w_complete_nxt = r_complete;
      w_ld_err_nxt   = r_ld_err;
      w_done_nxt     = 1'b0;
      w_we           = 1'b0;
      w_waddr        = r_ptr[AW-1:0];
      w_wdata        = DW'(NOP_WORD);

      case (r_state)
         CLEAR: begin
            w_we = 1'b1;
            if (r_ptr[AW-1:0] == LAST_ADDR) begin
               w_state_nxt    = HOLD;
               w_ptr_nxt      = PTR_ZERO;
               w_hold_cnt_nxt = 4'd0;
               w_complete_nxt = 1'b0;
            end else begin
               w_ptr_nxt = r_ptr + PTR_ONE;
            end
         end
         IDLE: begin
            if (i_ld_start) begin
               w_state_nxt    = LOAD;
               w_ptr_nxt      = PTR_ZERO;
               w_ld_err_nxt   = 1'b0;
               w_complete_nxt = 1'b0;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         LOAD: begin
            // abort wins over a byte presented in the same cycle
            if (i_ld_abort) begin
               w_state_nxt    = HOLD;
               w_ld_err_nxt   = 1'b1;
               w_complete_nxt = 1'b0;
               w_hold_cnt_nxt = 4'd0;
            end else if (i_ld_valid && r_ld_ready && !r_ptr[AW]) begin
               w_we      = 1'b1;
               w_wdata   = i_ld_data;
               w_ptr_nxt = r_ptr + PTR_ONE;
               if (r_ptr[AW-1:0] == LAST_ADDR) begin
                  w_state_nxt    = HOLD;
                  w_complete_nxt = 1'b1;
                  w_hold_cnt_nxt = 4'd0;
               end else begin
                  w_state_nxt = LOAD;
               end
            end else begin
               w_state_nxt = LOAD;
            end
         end
         HOLD: begin
            if (r_hold_cnt == HOLD_LAST) begin
               w_state_nxt    = IDLE;
               w_hold_cnt_nxt = 4'd0;
               w_done_nxt     = r_complete;
            end else begin
               w_hold_cnt_nxt = r_hold_cnt + HOLD_ONE;
            end
         end
         default: begin
            w_state_nxt = CLEAR;
            w_ptr_nxt   = PTR_ZERO;
         end
      endcase
   end

   // state and registered outputs; outputs decode the next state so they
   // line up with the state they describe
   always_ff @(posedge i_clk) begin
      if (!i_n_reset) begin
         r_state       <= CLEAR;
         r_ptr         <= PTR_ZERO;
         r_hold_cnt    <= 4'd0;
         r_complete    <= 1'b0;
         r_ld_err      <= 1'b0;
         r_ld_ready    <= 1'b0;
         r_ld_busy     <= 1'b1;
         r_ld_done     <= 1'b0;
         r_cpu_n_reset <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_ptr         <= w_ptr_nxt;
         r_hold_cnt    <= w_hold_cnt_nxt;
         r_complete    <= w_complete_nxt;
         r_ld_err      <= w_ld_err_nxt;
         r_ld_ready    <= (w_state_nxt == LOAD);
         r_ld_busy     <= (w_state_nxt != IDLE);
         r_ld_done     <= w_done_nxt;
         r_cpu_n_reset <= (w_state_nxt == IDLE);
      end
   end

   prog_loader_rom_mem #(
      .AW (AW),
      .DW (DW)
   ) u_mem (
      .i_clk   (i_clk),
      .i_we    (w_we && i_n_reset),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_raddr (i_addr),
      .o_rdata (o_data)
   );

   assign o_ld_ready    = r_ld_ready;
   assign o_ld_busy     = r_ld_busy;
   assign o_ld_done     = r_ld_done;
   assign o_ld_err      = r_ld_err;
   assign o_cpu_n_reset = r_cpu_n_reset;

endmodule
